// File: rtl/dmem_pkg.sv
// Shared constants, decode enum and lane-merge helper for the data-side memory responder.
package dmem_pkg;

  localparam logic [31:0] DEF_DMEM_BASE  = 32'h1000_2000;
  localparam int unsigned DEF_DMEM_WORDS = 2048;
  localparam logic [31:0] DEF_MMIO_BASE  = 32'hFFFF_0000;

  // MMIO word offsets within the 64-byte window (Addr[5:2])
  localparam logic [3:0] MTIME_LO    = 4'd0;
  localparam logic [3:0] MTIME_HI    = 4'd1;
  localparam logic [3:0] MTIMECMP_LO = 4'd2;
  localparam logic [3:0] MTIMECMP_HI = 4'd3;
  localparam logic [3:0] TOHOST      = 4'd4;

  typedef enum logic [1:0] {SEL_RAM, SEL_MMIO, SEL_NONE} sel_e;

  // Replace only the byte lanes selected by be; other lanes keep old_v.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-enabled 4-lane data RAM: asynchronous read, synchronous write, no reset.
module dmem_ram #(
  parameter int unsigned WORDS = 2048,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  // Write each enabled lane at the clock edge; disabled lanes are left untouched.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-port slave: address decode, data RAM, and MMIO timer/compare/tohost registers.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
  parameter int unsigned DMEM_WORDS = DEF_DMEM_WORDS,
  parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  byte_enable,
  output logic [31:0] ReadData,
  output logic        timer_irq,
  output logic        halt,
  output logic [31:0] tohost_val
);

  localparam int unsigned AW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DMEM_WORDS);

  logic [31:0] ram_off;
  logic [3:0]  mmio_off;
  sel_e        sel;
  logic        ram_we;
  logic        mmio_we;
  logic [31:0] ram_rdata;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] tohost_q, tohost_d;
  logic        halt_q, halt_d;
  logic        irq_q, irq_d;

  // Unsigned subtract makes addresses below the base wrap high, so one compare covers both bounds.
  assign ram_off  = Addr - DMEM_BASE;
  assign mmio_off = Addr[5:2];

  // Address decode into RAM / MMIO / unmapped.
  always_comb begin
    sel = SEL_NONE;
    if (ram_off < RAM_BYTES)                 sel = SEL_RAM;
    else if (Addr[31:6] == MMIO_BASE[31:6])  sel = SEL_MMIO;
  end

  assign ram_we  = MemWrite && (sel == SEL_RAM);
  assign mmio_we = MemWrite && (sel == SEL_MMIO);

  dmem_ram #(
    .WORDS (DMEM_WORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .idx_i   (ram_off[AW+1:2]),
    .wdata_i (WriteData),
    .be_i    (byte_enable),
    .rdata_o (ram_rdata)
  );

  // MMIO next state; a write to either mtime half replaces the increment for all 64 bits.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    tohost_d   = tohost_q;
    halt_d     = halt_q;
    irq_d      = (mtime_q >= mtimecmp_q);
    if (mmio_we) begin
      case (mmio_off)
        MTIME_LO:    mtime_d = {mtime_q[63:32], lane_merge(mtime_q[31:0], WriteData, byte_enable)};
        MTIME_HI:    mtime_d = {lane_merge(mtime_q[63:32], WriteData, byte_enable), mtime_q[31:0]};
        MTIMECMP_LO: mtimecmp_d[31:0]  = lane_merge(mtimecmp_q[31:0], WriteData, byte_enable);
        MTIMECMP_HI: mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], WriteData, byte_enable);
        TOHOST: begin
          tohost_d = lane_merge(tohost_q, WriteData, byte_enable);
          if (tohost_d != '0) halt_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // MMIO register state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      tohost_q   <= '0;
      halt_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      tohost_q   <= tohost_d;
      halt_q     <= halt_d;
      irq_q      <= irq_d;
    end
  end

  // Combinational read mux; unmapped space and unused MMIO offsets read zero.
  always_comb begin
    ReadData = '0;
    case (sel)
      SEL_RAM: ReadData = ram_rdata;
      SEL_MMIO: begin
        case (mmio_off)
          MTIME_LO:    ReadData = mtime_q[31:0];
          MTIME_HI:    ReadData = mtime_q[63:32];
          MTIMECMP_LO: ReadData = mtimecmp_q[31:0];
          MTIMECMP_HI: ReadData = mtimecmp_q[63:32];
          TOHOST:      ReadData = tohost_q;
          default:     ReadData = '0;
        endcase
      end
      default: ReadData = '0;
    endcase
  end

  assign timer_irq  = irq_q;
  assign halt       = halt_q;
  assign tohost_val = tohost_q;

endmodule
